// File: rtl/neuron_preact_mac.sv
// neuron_preact_mac
// Pre-activation multiply-accumulate for one neuron: z = bias + sum(x_i * w_i),
// all operands signed Q8.8. Products are kept full precision (Q16.16) and summed
// into a 40-bit Q24.16 accumulator. The result is floored back to Q8.8 and
// saturated for the downstream sigmoid stage.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   x_in/w_in/bias_in/in_last beat valid
//   in_ready   block can accept a beat (state decode only)
//   x_in       activation, signed Q8.8
//   w_in       weight, signed Q8.8
//   bias_in    bias, signed Q8.8, sampled on the first beat of a vector
//   in_last    final beat of a vector
//   out_valid  z_out/sat/trunc valid
//   out_ready  downstream accepts the result
//   z_out      pre-activation, signed Q8.8
//   sat        z_out was clamped
//   trunc      vector closed by MAX_TERMS instead of in_last
module neuron_preact_mac #(
   parameter int unsigned MAX_TERMS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] x_in,
   input  logic [15:0] w_in,
   input  logic [15:0] bias_in,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] z_out,
   output logic        sat,
   output logic        trunc
);

   localparam int unsigned CNT_W  = $clog2(MAX_TERMS + 1);
   localparam int unsigned ACC_W  = 40;
   localparam int unsigned PROD_W = 32;

   localparam logic signed [31:0] Z_MAX = 32'sd32767;
   localparam logic signed [31:0] Z_MIN = -32'sd32768;

   typedef enum logic {
      ST_ACC = 1'b0,
      ST_OUT = 1'b1
   } state_t;

   state_t                    r_state;
   logic signed [ACC_W-1:0]   r_acc;
   logic        [CNT_W-1:0]   r_cnt;
   logic                      r_in_ready;
   logic                      r_out_valid;
   logic        [15:0]        r_z;
   logic                      r_sat;
   logic                      r_trunc;

   logic signed [PROD_W-1:0]  w_x32;
   logic signed [PROD_W-1:0]  w_w32;
   logic signed [PROD_W-1:0]  w_prod;
   logic signed [ACC_W-1:0]   w_prod40;
   logic signed [ACC_W-1:0]   w_bias40;
   logic signed [ACC_W-1:0]   w_acc_base;
   logic signed [ACC_W-1:0]   w_acc_next;
   logic signed [31:0]        w_z32;
   logic        [15:0]        w_z_sat;
   logic                      w_sat;
   logic                      w_first;
   logic                      w_at_max;
   logic                      w_accept;

   // Full-precision Q16.16 product; operands widened first so nothing is lost.
   assign w_x32    = 32'($signed(x_in));
   assign w_w32    = 32'($signed(w_in));
   assign w_prod   = w_x32 * w_w32;
   assign w_prod40 = 40'(w_prod);

   // Q8.8 bias aligned to Q24.16 (shift left by 8, sign-extended).
   assign w_bias40 = {{16{bias_in[15]}}, bias_in, 8'h00};

   assign w_first    = (r_cnt == '0);
   assign w_acc_base = w_first ? w_bias40 : r_acc;
   assign w_acc_next = w_acc_base + w_prod40;

   // Arithmetic shift right by 8 (floor), then clamp to the Q8.8 range.
   assign w_z32 = w_acc_next[ACC_W-1:8];

   always_comb begin
      w_z_sat = w_z32[15:0];
      w_sat   = 1'b0;
      if (w_z32 > Z_MAX) begin
         w_z_sat = 16'h7FFF;
         w_sat   = 1'b1;
      end else if (w_z32 < Z_MIN) begin
         w_z_sat = 16'h8000;
         w_sat   = 1'b1;
      end
   end

   assign w_at_max = (r_cnt == CNT_W'(MAX_TERMS - 1));
   assign w_accept = in_valid && r_in_ready;

   // Two-state controller: accumulate beats, then hold the result until taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_ACC;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_z         <= 16'h0000;
         r_sat       <= 1'b0;
         r_trunc     <= 1'b0;
      end else begin
         case (r_state)
            ST_ACC: begin
               if (w_accept) begin
                  r_acc <= w_acc_next;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (in_last || w_at_max) begin
                     r_state     <= ST_OUT;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_z         <= w_z_sat;
                     r_sat       <= w_sat;
                     r_trunc     <= w_at_max && !in_last;
                  end
               end
            end
            ST_OUT: begin
               // Beats are ignored here; the handshake edge only returns to ACC.
               if (out_ready) begin
                  r_state     <= ST_ACC;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
                  r_acc       <= '0;
                  r_cnt       <= '0;
               end
            end
            default: begin
               r_state <= ST_ACC;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign z_out     = r_z;
   assign sat       = r_sat;
   assign trunc     = r_trunc;

endmodule

// File: tb/tb_neuron_preact_mac.sv
// tb_neuron_preact_mac
// Directed bench for neuron_preact_mac with hand-computed expected results.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_neuron_preact_mac;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x_in;
   logic [15:0] w_in;
   logic [15:0] bias_in;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] z_out;
   logic        sat;
   logic        trunc;

   int n_checks = 0;
   int n_pass   = 0;

   neuron_preact_mac #(.MAX_TERMS(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .w_in      (w_in),
      .bias_in   (bias_in),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z_out     (z_out),
      .sat       (sat),
      .trunc     (trunc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Present one beat for exactly one rising edge; returns on the next falling edge.
   task automatic beat(input logic [15:0] x, input logic [15:0] w,
                       input logic [15:0] b, input logic last);
      x_in     = x;
      w_in     = w;
      bias_in  = b;
      in_last  = last;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Complete the output handshake and confirm the return to ACC.
   task automatic drain(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_drain_ov"}, 32'(out_valid), 32'd0);
      chk({tag, "_drain_rdy"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x_in      = '0;
      w_in      = '0;
      bias_in   = '0;
      in_last   = 1'b0;

      // Reset values
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_z", 32'(z_out), 32'h0000);
      chk("rst_sat", 32'(sat), 32'd0);
      chk("rst_trunc", 32'(trunc), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single term 1.0 * 2.0 = 2.0, result one cycle after the closing beat
      beat(16'h0100, 16'h0200, 16'h0000, 1'b1);
      chk("t1_ov", 32'(out_valid), 32'd1);
      chk("t1_rdy", 32'(in_ready), 32'd0);
      chk("t1_z", 32'(z_out), 32'h0200);
      chk("t1_sat", 32'(sat), 32'd0);
      chk("t1_trunc", 32'(trunc), 32'd0);
      drain("t1");

      // Bias -1.0 + 0.25 - 0.5 = -1.25; bias on later beats must be ignored
      beat(16'h0080, 16'h0080, 16'hFF00, 1'b0);
      chk("t2_mid_ov", 32'(out_valid), 32'd0);
      beat(16'h0100, 16'hFF80, 16'h1234, 1'b1);
      chk("t2_z", 32'(z_out), 32'hFEC0);
      chk("t2_sat", 32'(sat), 32'd0);
      drain("t2");

      // Positive saturation
      for (int i = 0; i < 4; i++) beat(16'h7FFF, 16'h7FFF, 16'h0000, i == 3);
      chk("t3p_z", 32'(z_out), 32'h7FFF);
      chk("t3p_sat", 32'(sat), 32'd1);
      drain("t3p");

      // Negative saturation
      for (int i = 0; i < 4; i++) beat(16'h7FFF, 16'h8001, 16'h0000, i == 3);
      chk("t3n_z", 32'(z_out), 32'h8000);
      chk("t3n_sat", 32'(sat), 32'd1);
      chk("t3n_trunc", 32'(trunc), 32'd0);
      drain("t3n");

      // Back-pressure: result held, beats ignored while in OUT
      beat(16'h0100, 16'h0100, 16'h0000, 1'b1);
      x_in     = 16'h7FFF;
      w_in     = 16'h7FFF;
      bias_in  = 16'h0400;
      in_last  = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold_z", 32'(z_out), 32'h0100);
         chk("t4_hold_rdy", 32'(in_ready), 32'd0);
         chk("t4_hold_ov", 32'(out_valid), 32'd1);
      end
      // in_valid stays high across the handshake edge; it must not be taken
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      chk("t4_rel_ov", 32'(out_valid), 32'd0);
      chk("t4_rel_rdy", 32'(in_ready), 32'd1);
      beat(16'h0100, 16'h0200, 16'h0000, 1'b1);
      chk("t4_next_z", 32'(z_out), 32'h0200);
      chk("t4_next_sat", 32'(sat), 32'd0);
      drain("t4");

      // MAX_TERMS closure without in_last: 64 * (1.0 * 1/256) = 0.25
      for (int i = 0; i < 63; i++) beat(16'h0100, 16'h0001, 16'h0000, 1'b0);
      chk("t5_63_ov", 32'(out_valid), 32'd0);
      beat(16'h0100, 16'h0001, 16'h0000, 1'b0);
      chk("t5_ov", 32'(out_valid), 32'd1);
      chk("t5_z", 32'(z_out), 32'h0040);
      chk("t5_trunc", 32'(trunc), 32'd1);
      chk("t5_sat", 32'(sat), 32'd0);
      drain("t5");

      // in_last on the MAX_TERMS-th beat is a normal close
      for (int i = 0; i < 64; i++) beat(16'h0100, 16'h0001, 16'h0000, i == 63);
      chk("t6_z", 32'(z_out), 32'h0040);
      chk("t6_trunc", 32'(trunc), 32'd0);
      drain("t6");

      // Reset mid-vector discards partial terms
      beat(16'h0100, 16'h0100, 16'h0500, 1'b0);
      beat(16'h0100, 16'h0100, 16'h0500, 1'b0);
      rst = 1'b1;
      #1;
      chk("t7_rst_ov", 32'(out_valid), 32'd0);
      chk("t7_rst_z", 32'(z_out), 32'h0000);
      chk("t7_rst_rdy", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      beat(16'h0100, 16'h0100, 16'h0000, 1'b1);
      chk("t7_z", 32'(z_out), 32'h0100);
      chk("t7_sat", 32'(sat), 32'd0);

      // Reset while holding a result discards it
      rst = 1'b1;
      #1;
      chk("t8_rst_ov", 32'(out_valid), 32'd0);
      chk("t8_rst_z", 32'(z_out), 32'h0000);
      chk("t8_rst_rdy", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      beat(16'h0080, 16'h0100, 16'h0000, 1'b1);
      chk("t8_z", 32'(z_out), 32'h0080);
      drain("t8");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
